// File: rtl/fifo_lane.sv
// fifo_lane: per-lane FIFO behind the demux with occupancy flags and a sticky overflow error.
module fifo_lane #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 pop,
    input  logic [ADDR_SIZE:0]   umbral_bajo,
    input  logic [ADDR_SIZE:0]   umbral_alto,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic                 fifo_error
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic [ADDR_SIZE:0]   count;
    logic                 wr_en, rd_en;
    always_comb begin
        fifo_empty   = count == '0;
        fifo_full    = count == (ADDR_SIZE+1)'(DEPTH);
        almost_empty = count <= umbral_bajo;
        almost_full  = count >= umbral_alto;
        // a pop frees a slot in the same edge, so a full FIFO still accepts push+pop
        wr_en        = push && (!fifo_full || pop);
        rd_en        = pop && !fifo_empty;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            valid_out <= rd_en;
            if (push && fifo_full && !pop) fifo_error <= 1'b1;
            count <= (wr_en && !rd_en) ? count + 1'b1 :
                     (rd_en && !wr_en) ? count - 1'b1 : count;
        end
    end
endmodule

// File: tb/tb_fifo_lane.sv
// tb_fifo_lane: vector table for the single-step behaviour plus a scoreboard for streaming and reset corners.
module tb_fifo_lane;
    logic       clk = 1'b0;
    logic       reset, push, pop;
    logic [5:0] data_in, data_out;
    logic [2:0] umbral_bajo, umbral_alto;
    logic       valid_out, fifo_empty, fifo_full, almost_empty, almost_full, fifo_error;
    int         errors = 0;
    int         checks = 0;

    fifo_lane dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
        .data_out(data_out), .valid_out(valid_out), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .almost_empty(almost_empty), .almost_full(almost_full),
        .fifo_error(fifo_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, pu, po;
        logic [5:0] din;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[$];
    logic [5:0] sb[$];

    function automatic logic [11:0] outs();
        return {valid_out, data_out, fifo_empty, fifo_full, almost_empty, almost_full, fifo_error};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, pu, po, input logic [5:0] din,
                       input logic v, input logic [5:0] d, input logic e, f, ae, af, err);
        vec_t t;
        t.rst = rst; t.pu = pu; t.po = po; t.din = din;
        t.exp = {v, d, e, f, ae, af, err};
        vecs.push_back(t);
    endtask

    task automatic step(input logic pu, po, input logic [5:0] din);
        push = pu; pop = po; data_in = din;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent, got;
        logic [5:0] e;
        // thresholds: umbral_bajo=1, umbral_alto=3 unless noted
        add(0,1,0,6'h3F, 0,6'h00, 0,0,1,0,0);
        add(0,1,0,6'h3E, 0,6'h00, 0,0,0,0,0);
        add(0,1,0,6'h3D, 0,6'h00, 0,0,0,1,0);
        add(0,1,0,6'h3C, 0,6'h00, 0,1,0,1,0);
        add(0,1,0,6'h3B, 0,6'h00, 0,1,0,1,1);
        add(0,0,1,6'h00, 1,6'h3F, 0,0,0,1,1);
        add(0,0,1,6'h00, 1,6'h3E, 0,0,0,0,1);
        add(0,0,1,6'h00, 1,6'h3D, 0,0,1,0,1);
        add(0,0,1,6'h00, 1,6'h3C, 1,0,1,0,1);
        add(0,0,1,6'h00, 0,6'h3C, 1,0,1,0,1);
        add(0,0,1,6'h00, 0,6'h3C, 1,0,1,0,1);
        add(0,0,1,6'h00, 0,6'h3C, 1,0,1,0,1);
        add(1,1,1,6'h2A, 0,6'h00, 1,0,1,0,0);
        add(0,0,1,6'h00, 0,6'h00, 1,0,1,0,0);
        add(0,1,0,6'h01, 0,6'h00, 0,0,1,0,0);
        add(0,1,0,6'h02, 0,6'h00, 0,0,0,0,0);
        add(0,1,0,6'h03, 0,6'h00, 0,0,0,1,0);
        add(0,1,0,6'h04, 0,6'h00, 0,1,0,1,0);
        add(0,1,1,6'h05, 1,6'h01, 0,1,0,1,0);
        add(0,0,1,6'h00, 1,6'h02, 0,0,0,1,0);
        add(0,0,1,6'h00, 1,6'h03, 0,0,0,0,0);
        add(0,0,1,6'h00, 1,6'h04, 0,0,1,0,0);
        add(0,0,1,6'h00, 1,6'h05, 1,0,1,0,0);
        add(0,1,1,6'h0A, 0,6'h05, 0,0,1,0,0);
        add(0,0,1,6'h00, 1,6'h0A, 1,0,1,0,0);
        add(0,1,0,6'h11, 0,6'h0A, 0,0,1,0,0);
        add(0,1,0,6'h12, 0,6'h0A, 0,0,0,0,0);

        // reset held with push/pop high; umbral_alto=0 forces almost_full
        reset = 1; push = 1; pop = 1; data_in = 6'h15; umbral_bajo = 3'd1; umbral_alto = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'({1'b0, 6'h00, 4'b1011, 1'b0}));
        umbral_alto = 3'd3;
        #1;
        chk("reset_af_off", 32'(outs()), 32'({1'b0, 6'h00, 4'b1010, 1'b0}));

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            step(vecs[i].pu, vecs[i].po, vecs[i].din);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // thresholds move mid-cycle at count 2; flags follow without an edge
        push = 0; pop = 0;
        umbral_alto = 3'd2;
        #1;
        chk("af_thresh_drop", 32'(almost_full), 32'd1);
        umbral_alto = 3'd3;
        #1;
        chk("af_thresh_back", 32'(almost_full), 32'd0);
        umbral_bajo = 3'd2;
        #1;
        chk("ae_thresh_raise", 32'(almost_empty), 32'd1);
        umbral_bajo = 3'd1;

        // stream 10 words with overlapping push/pop across pointer wrap
        reset = 1; push = 0; pop = 0;
        @(posedge clk); #1;
        reset = 0;
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            push = sent < 10;
            data_in = 6'(sent);
            if (push) begin
                sb.push_back(6'(sent));
                sent++;
            end
            pop = c >= 1;
            @(posedge clk); #1;
            if (valid_out) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_extra: got %0h expected none", data_out);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("stream%0d", got), 32'(data_out), 32'(e));
                end
                got++;
            end
        end
        chk("stream_count", got, 10);

        // asynchronous reset between edges while a word is on data_out
        step(1, 0, 6'h20);
        step(1, 1, 6'h21);
        chk("pre_reset", 32'({valid_out, data_out}), 32'({1'b1, 6'h20}));
        #3 reset = 1;
        #1;
        chk("async_reset", 32'(outs()), 32'({1'b0, 6'h00, 4'b1010, 1'b0}));
        step(0, 0, 6'h00);
        reset = 0;
        step(1, 0, 6'h33);
        step(0, 1, 6'h00);
        chk("post_reset_word", 32'({valid_out, data_out}), 32'({1'b1, 6'h33}));
        step(0, 1, 6'h00);
        chk("post_reset_empty", 32'(outs()), 32'({1'b0, 6'h33, 4'b1010, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
